banked_scalar_reg_file: RTL and testbench
=========================================

Name: banked_scalar_reg_file

Overview:
- Next-generation scalar register file: one bank of NUM_REGS scalar registers per warp, for NUM_WARPS warps, in a single block.
- Two read ports with a registered 1-cycle read and write-to-read bypass.
- Two write ports: a pipeline write-back port and an LSU load-return port with a valid/ready handshake.
- Per-warp load scoreboard (pending bits) reporting RAW/WAW hazards to the issue stage, plus per-warp execution-mask export.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, register width in bits.
- NUM_WARPS, 4, number of warp banks (>=1).
- NUM_REGS, 32, registers per warp (power of two, >=4).
- Derived, not overridable: WA = max(1,$clog2(NUM_WARPS)); RA = $clog2(NUM_REGS); MASK_REG = NUM_REGS-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rd_req_valid  in  1  read request.
- rd_warp  in  WA  warp index for the read.
- rd_rs1_addr  in  RA  source 1 register index.
- rd_rs2_addr  in  RA  source 2 register index.
- rd_rd_addr  in  RA  destination index, used for the hazard check only.
- rd_valid  out  1  read data valid, one cycle after the request.
- rs1  out  DATA_WIDTH  source 1 data.
- rs2  out  DATA_WIDTH  source 2 data.
- rd_hazard  out  1  combinational: rs1, rs2 or rd of the request is pending in rd_warp.
- wb_valid  in  1  pipeline write-back; always accepted.
- wb_warp  in  WA  write-back warp index.
- wb_addr  in  RA  write-back register index.
- wb_data  in  DATA_WIDTH  write-back data (already muxed: ALU/imm/PC+1/vector-to-scalar).
- lsu_valid  in  1  load return valid.
- lsu_ready  out  1  load return accepted.
- lsu_warp  in  WA  load return warp index.
- lsu_addr  in  RA  load return register index.
- lsu_data  in  DATA_WIDTH  load return data.
- rsv_valid  in  1  load issue: reserve the destination register.
- rsv_warp  in  WA  reservation warp index.
- rsv_addr  in  RA  reservation register index.
- exec_mask  out  NUM_WARPS*DATA_WIDTH  register MASK_REG of each warp; warp w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
- sb_error  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (reset=0, asynchronous) sets every warp as follows:
  - r0 = 0, r1 = all-ones, MASK_REG = all-ones, all other registers = 0.
  - All pending bits = 0.
  - rd_valid = 0, rs1 = rs2 = 0, sb_error = 0.
  - Reset release is synchronous to clk. Reset mid-operation discards in-flight reads and all reservations.
- r0 of every warp reads 0 at all times. Writes to r0 are dropped from both ports and still clear its pending bit.
- Read path:
  - When rd_req_valid is sampled high, the next cycle has rd_valid=1 and rs1/rs2 = register contents.
  - rd_valid=0 otherwise. rs1/rs2 hold their last value while rd_valid=0.
- Bypass: if a write commits in the same cycle as the read request, to the same warp and index, rs1/rs2 return the new data.
  - The accepted write-back wins over an LSU write.
- Write ports:
  - wb_valid has priority, and lsu_ready = ~wb_valid (combinational).
  - An LSU write commits on lsu_valid && lsu_ready.
  - At most one register write commits per cycle.
  - An LSU return blocked by a write-back must hold its data and indices stable until accepted.
- Scoreboard:
  - rsv_valid sets pending[rsv_warp][rsv_addr] at the clock edge.
  - An accepted LSU write clears pending[lsu_warp][lsu_addr].
  - A write-back does not alter pending bits.
  - Reserve and LSU clear of the same bit in the same cycle leaves it set: a new load is reserved while the old one retires.
- rd_hazard = rd_req_valid && (pending[rd_warp][rs1] | pending[rd_warp][rs2] | pending[rd_warp][rd]).
  - rd_hazard is combinational from the current pending state.
  - The pending bit of r0 never causes a hazard.
  - rd_hazard does not block the read; the issue stage must stall.
- sb_error is set, and stays set until reset, on either condition:
  - rsv_valid on a bit already pending that is not being cleared in the same cycle.
  - An accepted LSU write to a non-pending register.
  - The offending write or reserve still takes effect.
- exec_mask is driven combinationally from the register contents; a write to MASK_REG appears the cycle after commit.
- Arithmetic: none; all indices are unsigned. A warp index >= NUM_WARPS is out of range: its reads return 0, and its writes and reservations are ignored.

Test Plan:
Configuration for all scenarios: NUM_WARPS=4, NUM_REGS=32, DATA_WIDTH=32.
- Reset then read warp 2 with rs1=1, rs2=31 -> next cycle rd_valid=1, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF; exec_mask = all-ones for every warp.
- wb warp0 r5=0x1234 and wb warp3 r5=0xBEEF, then read warp0 r5 and warp3 r5 -> 0x1234 and 0xBEEF; banks are isolated.
- Same-cycle wb warp1 r7=0xA5A5 and read warp1 rs1=r7 -> rs1=0xA5A5 next cycle (bypass); a write to r0=0x55 reads back 0.
- lsu_valid held with warp2 r9=0xCAFE while wb_valid=1 for 3 cycles -> lsu_ready=0 for 3 cycles, then commits; a later read returns 0xCAFE.
- Reserve warp1 r4, then read rs2=r4 -> rd_hazard=1; LSU return to warp1 r4 -> pending cleared, rd_hazard=0 next cycle, sb_error=0.
- Reserve warp0 r6 twice without a return -> sb_error=1 and it stays 1. Then assert reset mid-read -> rd_valid=0 and sb_error=0 immediately (asynchronous).

Source files
------------

// File: rtl/banked_scalar_reg_file.sv
// Banked scalar register file: one register bank per warp, two registered read
// ports with write bypass, a write-back port and an LSU port, and a per-warp load scoreboard.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module banked_scalar_reg_file #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned NUM_REGS   = 32,
    localparam int unsigned WA = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int unsigned RA = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rd_req_valid,
    input  logic [WA-1:0]                   rd_warp,
    input  logic [RA-1:0]                   rd_rs1_addr,
    input  logic [RA-1:0]                   rd_rs2_addr,
    input  logic [RA-1:0]                   rd_rd_addr,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rs1,
    output logic [DATA_WIDTH-1:0]           rs2,
    output logic                            rd_hazard,
    input  logic                            wb_valid,
    input  logic [WA-1:0]                   wb_warp,
    input  logic [RA-1:0]                   wb_addr,
    input  logic [DATA_WIDTH-1:0]           wb_data,
    input  logic                            lsu_valid,
    output logic                            lsu_ready,
    input  logic [WA-1:0]                   lsu_warp,
    input  logic [RA-1:0]                   lsu_addr,
    input  logic [DATA_WIDTH-1:0]           lsu_data,
    input  logic                            rsv_valid,
    input  logic [WA-1:0]                   rsv_warp,
    input  logic [RA-1:0]                   rsv_addr,
    output logic [NUM_WARPS*DATA_WIDTH-1:0] exec_mask,
    output logic                            sb_error
);

    localparam int unsigned MASK_REG = NUM_REGS - 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_WARPS][NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_WARPS][NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q [NUM_WARPS];
    logic [NUM_REGS-1:0]   pend_d [NUM_WARPS];
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic                  err_q, err_d;

    logic                  we;
    logic [WA-1:0]         w_warp;
    logic [RA-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  lsu_acc;
    logic [NUM_REGS-1:0]   pend_rd;

    function automatic logic warp_ok(input logic [WA-1:0] w);
        return 32'(w) < NUM_WARPS;
    endfunction

    assign lsu_ready = ~wb_valid;
    assign lsu_acc   = lsu_valid & ~wb_valid;

    // Single commit slot: write-back always wins; r0 and out-of-range warps never commit.
    always_comb begin
        we     = 1'b0;
        w_warp = wb_warp;
        w_addr = wb_addr;
        w_data = wb_data;
        if (wb_valid) begin
            we = warp_ok(wb_warp) && (wb_addr != '0);
        end else if (lsu_valid) begin
            we     = warp_ok(lsu_warp) && (lsu_addr != '0);
            w_warp = lsu_warp;
            w_addr = lsu_addr;
            w_data = lsu_data;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[w_warp][w_addr] = w_data;
        end
    end

    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (rd_req_valid) begin
            rs1_d = '0;
            rs2_d = '0;
            if (warp_ok(rd_warp)) begin
                if (rd_rs1_addr != '0) begin
                    rs1_d = (we && w_warp == rd_warp && w_addr == rd_rs1_addr)
                            ? w_data : regs_q[rd_warp][rd_rs1_addr];
                end
                if (rd_rs2_addr != '0) begin
                    rs2_d = (we && w_warp == rd_warp && w_addr == rd_rs2_addr)
                            ? w_data : regs_q[rd_warp][rd_rs2_addr];
                end
            end
        end
    end

    // Clear before set, so a same-cycle re-reserve of a retiring load stays pending.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (lsu_acc && warp_ok(lsu_warp)) begin
            if (!pend_q[lsu_warp][lsu_addr]) begin
                err_d = 1'b1;
            end
            pend_d[lsu_warp][lsu_addr] = 1'b0;
        end
        if (rsv_valid && warp_ok(rsv_warp)) begin
            if (pend_q[rsv_warp][rsv_addr] &&
                !(lsu_acc && lsu_warp == rsv_warp && lsu_addr == rsv_addr)) begin
                err_d = 1'b1;
            end
            pend_d[rsv_warp][rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pend_q[w] <= '0;
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (r == 1 || r == MASK_REG) begin
                        regs_q[w][r] <= '1;
                    end else begin
                        regs_q[w][r] <= '0;
                    end
                end
            end
            rd_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_req_valid;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            err_q      <= err_d;
        end
    end

    assign pend_rd   = warp_ok(rd_warp) ? pend_q[rd_warp] : '0;
    assign rd_hazard = rd_req_valid &
                       (((rd_rs1_addr != '0) & pend_rd[rd_rs1_addr]) |
                        ((rd_rs2_addr != '0) & pend_rd[rd_rs2_addr]) |
                        ((rd_rd_addr  != '0) & pend_rd[rd_rd_addr]));

    assign rd_valid = rd_valid_q;
    assign rs1      = rs1_q;
    assign rs2      = rs2_q;
    assign sb_error = err_q;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
        assign exec_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w][MASK_REG];
    end

endmodule

// File: tb/tb_banked_scalar_reg_file.sv
// Bench for banked_scalar_reg_file: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based reference model.
module tb_banked_scalar_reg_file;
    localparam int NW = 4;
    localparam int NR = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_req_valid;
    logic [1:0]      rd_warp;
    logic [4:0]      rd_rs1_addr, rd_rs2_addr, rd_rd_addr;
    logic            rd_valid;
    logic [DW-1:0]   rs1, rs2;
    logic            rd_hazard;
    logic            wb_valid;
    logic [1:0]      wb_warp;
    logic [4:0]      wb_addr;
    logic [DW-1:0]   wb_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [1:0]      lsu_warp;
    logic [4:0]      lsu_addr;
    logic [DW-1:0]   lsu_data;
    logic            rsv_valid;
    logic [1:0]      rsv_warp;
    logic [4:0]      rsv_addr;
    logic [NW*DW-1:0] exec_mask;
    logic            sb_error;

    banked_scalar_reg_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_warp(rd_warp),
        .rd_rs1_addr(rd_rs1_addr), .rd_rs2_addr(rd_rs2_addr), .rd_rd_addr(rd_rd_addr),
        .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2), .rd_hazard(rd_hazard),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_data(wb_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_warp(lsu_warp),
        .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rsv_valid(rsv_valid), .rsv_warp(rsv_warp), .rsv_addr(rsv_addr),
        .exec_mask(exec_mask), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    // Reference state: register contents, pending bits, sticky error, read outputs.
    logic [DW-1:0] mregs [NW][NR];
    bit            mpend [NW][NR];
    bit            merr, mvalid;
    logic [DW-1:0] mrs1, mrs2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++) begin
                mregs[w][r] = (r == 1 || r == NR - 1) ? 32'hFFFF_FFFF : 32'h0;
                mpend[w][r] = 1'b0;
            end
        merr = 1'b0; mvalid = 1'b0; mrs1 = '0; mrs2 = '0;
    endtask

    function automatic logic [DW-1:0] src_val(input int w, input int a, input bit wc,
                                              input int cw, input int ca, input logic [DW-1:0] cd);
        if (a == 0) return '0;
        if (wc && cw == w && ca == a) return cd;
        return mregs[w][a];
    endfunction

    function automatic bit exp_hazard();
        return rd_req_valid &&
               ((rd_rs1_addr != 0 && mpend[rd_warp][rd_rs1_addr]) ||
                (rd_rs2_addr != 0 && mpend[rd_warp][rd_rs2_addr]) ||
                (rd_rd_addr  != 0 && mpend[rd_warp][rd_rd_addr]));
    endfunction

    task automatic idle();
        rd_req_valid = 0; rd_warp = 0; rd_rs1_addr = 0; rd_rs2_addr = 0; rd_rd_addr = 0;
        wb_valid = 0; wb_warp = 0; wb_addr = 0; wb_data = 0;
        lsu_valid = 0; lsu_warp = 0; lsu_addr = 0; lsu_data = 0;
        rsv_valid = 0; rsv_warp = 0; rsv_addr = 0;
    endtask

    // Evaluate the model on the inputs about to be sampled, then advance one clock.
    task automatic cyc();
        bit wc, lacc, nerr;
        int cw, ca;
        logic [DW-1:0] cd, n1, n2;
        bit np [NW][NR];
        lacc = lsu_valid && !wb_valid;
        wc   = wb_valid || lsu_valid;
        if (wb_valid) begin cw = wb_warp; ca = wb_addr; cd = wb_data; end
        else begin cw = lsu_warp; ca = lsu_addr; cd = lsu_data; end
        n1 = mrs1; n2 = mrs2;
        if (rd_req_valid) begin
            n1 = src_val(rd_warp, rd_rs1_addr, wc, cw, ca, cd);
            n2 = src_val(rd_warp, rd_rs2_addr, wc, cw, ca, cd);
        end
        np = mpend; nerr = merr;
        if (lacc) begin
            if (!mpend[lsu_warp][lsu_addr]) nerr = 1'b1;
            np[lsu_warp][lsu_addr] = 1'b0;
        end
        if (rsv_valid) begin
            if (mpend[rsv_warp][rsv_addr] && !(lacc && lsu_warp == rsv_warp && lsu_addr == rsv_addr))
                nerr = 1'b1;
            np[rsv_warp][rsv_addr] = 1'b1;
        end
        @(posedge clk);
        if (wc && ca != 0) mregs[cw][ca] = cd;
        mpend = np; merr = nerr; mvalid = rd_req_valid; mrs1 = n1; mrs2 = n2;
        #1;
    endtask

    always @(negedge clk) begin
        logic [127:0] em;
        if (chk_en && reset) begin
            for (int w = 0; w < NW; w++) em[w*DW +: DW] = mregs[w][NR-1];
            check("rd_valid",  rd_valid,  mvalid);
            check("rs1",       rs1,       mrs1);
            check("rs2",       rs2,       mrs2);
            check("lsu_ready", lsu_ready, !wb_valid);
            check("rd_hazard", rd_hazard, exp_hazard());
            check("exec_mask", exec_mask, em);
            check("sb_error",  sb_error,  merr);
        end
    end

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    endfunction

    task automatic do_reset(input string tag);
        chk_en = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_sb_error"}, sb_error, 0);
        check({tag, "_rs1"},      rs1,      0);
        idle();
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_rd_valid",  rd_valid,  0);
        check("rst_sb_error",  sb_error,  0);
        check("rst_exec_mask", exec_mask, {128{1'b1}});
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Reset contents of warp 2: r1 and r31 are all-ones.
        rd_req_valid = 1; rd_warp = 2; rd_rs1_addr = 1; rd_rs2_addr = 31;
        cyc(); idle();
        check("s1_valid", rd_valid, 1);
        check("s1_rs1",   rs1, 32'hFFFF_FFFF);
        check("s1_rs2",   rs2, 32'hFFFF_FFFF);
        check("s1_mask",  exec_mask, {128{1'b1}});

        // Bank isolation.
        wb_valid = 1; wb_warp = 0; wb_addr = 5; wb_data = 32'h1234; cyc();
        wb_warp = 3; wb_data = 32'hBEEF; cyc(); idle();
        rd_req_valid = 1; rd_warp = 0; rd_rs1_addr = 5; rd_rs2_addr = 5; cyc();
        check("s2_w0", rs1, 32'h1234);
        rd_warp = 3; cyc();
        check("s2_w3", rs1, 32'hBEEF);
        rd_warp = 1; cyc();
        check("s2_w1", rs1, 32'h0);
        idle();

        // Same-cycle bypass and r0 write drop.
        wb_valid = 1; wb_warp = 1; wb_addr = 7; wb_data = 32'hA5A5;
        rd_req_valid = 1; rd_warp = 1; rd_rs1_addr = 7; rd_rs2_addr = 0; cyc();
        check("s3_bypass", rs1, 32'hA5A5);
        wb_addr = 0; wb_data = 32'h55; rd_rs1_addr = 0; cyc();
        check("s3_r0_byp", rs1, 32'h0);
        idle(); rd_req_valid = 1; rd_warp = 1; cyc(); idle();
        check("s3_r0", rs1, 32'h0);

        // LSU return blocked by write-back for three cycles.
        rsv_valid = 1; rsv_warp = 2; rsv_addr = 9; cyc(); idle();
        lsu_valid = 1; lsu_warp = 2; lsu_addr = 9; lsu_data = 32'hCAFE;
        wb_valid = 1; wb_warp = 0; wb_addr = 10; wb_data = 32'h77;
        repeat (3) begin
            #1 check("s4_blocked", lsu_ready, 0);
            cyc();
        end
        wb_valid = 0;
        #1 check("s4_ready", lsu_ready, 1);
        cyc(); idle();
        rd_req_valid = 1; rd_warp = 2; rd_rs1_addr = 9; cyc(); idle();
        check("s4_data", rs1, 32'hCAFE);
        rd_req_valid = 1; rd_warp = 0; rd_rs1_addr = 10; cyc(); idle();
        check("s4_wb", rs1, 32'h77);
        check("s4_err", sb_error, 0);

        // Scoreboard hazard then clear.
        rsv_valid = 1; rsv_warp = 1; rsv_addr = 4; cyc(); idle();
        rd_req_valid = 1; rd_warp = 1; rd_rs2_addr = 4;
        #1 check("s5_hazard", rd_hazard, 1);
        cyc(); idle();
        lsu_valid = 1; lsu_warp = 1; lsu_addr = 4; lsu_data = 32'h44; cyc(); idle();
        rd_req_valid = 1; rd_warp = 1; rd_rs2_addr = 4;
        #1 check("s5_no_hazard", rd_hazard, 0);
        cyc(); idle();
        check("s5_rs2", rs2, 32'h44);
        check("s5_err", sb_error, 0);

        // Double reservation is sticky until reset.
        rsv_valid = 1; rsv_warp = 0; rsv_addr = 6; cyc(); cyc(); idle();
        check("s6_err", sb_error, 1);
        repeat (3) cyc();
        check("s6_sticky", sb_error, 1);
        rd_req_valid = 1; rd_warp = 0; rd_rs1_addr = 1; cyc();
        check("s6_inflight", rd_valid, 1);
        #2 do_reset("s6_reset");
        rd_req_valid = 1; rd_warp = 0; rd_rs1_addr = 6;
        #1 check("s6_pend_clr", rd_hazard, 0);
        cyc(); idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit hold;
            hold = lsu_valid && wb_valid;
            rd_req_valid = 1'($urandom_range(0, 1));
            rd_warp      = 2'($urandom);
            rd_rs1_addr  = rnd_addr();
            rd_rs2_addr  = rnd_addr();
            rd_rd_addr   = rnd_addr();
            wb_valid     = ($urandom_range(0, 3) == 0);
            wb_warp      = 2'($urandom);
            wb_addr      = rnd_addr();
            wb_data      = $urandom;
            if (!hold) begin
                lsu_valid = 0;
                if ($urandom_range(0, 63) == 0) begin
                    lsu_valid = 1; lsu_warp = 2'($urandom); lsu_addr = rnd_addr();
                    lsu_data = $urandom;
                end else if ($urandom_range(0, 2) == 0) begin
                    int w, s;
                    w = $urandom_range(0, NW - 1);
                    s = $urandom_range(0, NR - 1);
                    for (int k = 0; k < NR; k++) begin
                        if (!lsu_valid && mpend[w][(s + k) % NR]) begin
                            lsu_valid = 1; lsu_warp = 2'(w); lsu_addr = 5'((s + k) % NR);
                            lsu_data = $urandom;
                        end
                    end
                end
            end
            rsv_valid = 0;
            if ($urandom_range(0, 3) == 0) begin
                rsv_warp = 2'($urandom);
                rsv_addr = rnd_addr();
                if (!mpend[rsv_warp][rsv_addr] || $urandom_range(0, 31) == 0) rsv_valid = 1;
            end
            cyc();
            if (i == 1500) do_reset("rand_reset");
        end
        idle();
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
